serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 102 ++++++++++
 tb/tb_serial_add_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial ripple adder sequencer: drives one external full-adder cell LSB first.
// Optional SERIAL_ADD_SUB_EN adds a 'sub' input for a - b via ~b plus carry-in 1.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_x,
    output logic             fa_y,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_carry
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] r_sh;
    logic             c_reg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] b_ld;
    logic             c_ld;
    logic [WIDTH-1:0] r_nxt;

`ifdef SERIAL_ADD_SUB_EN
    assign b_ld = sub ? ~b : b;
    assign c_ld = sub ? 1'b1 : cin;
`else
    assign b_ld = b;
    assign c_ld = cin;
`endif

    assign r_nxt = {fa_sum, r_sh};

    // Shift registers drain to zero by the last bit and c_reg is cleared on completion,
    // so the adder inputs are plain flop outputs that are 0 outside RUN.
    assign fa_x   = a_sh[0];
    assign fa_y   = b_sh[0];
    assign fa_cin = c_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            c_reg <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_ld;
                        c_reg <= c_ld;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sh  <= r_nxt[WIDTH-1:1];
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    c_reg <= fa_carry;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= r_nxt;
                        cout  <= fa_carry;
                        c_reg <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: 4-bit directed cases and 8-bit random cases against
// a plain-arithmetic model; an ideal full-adder cell is modelled per instance.
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic       s4 = 0, c4 = 0, sb4 = 0;
    logic [3:0] a4 = 0, b4 = 0, sum4;
    logic       busy4, done4, cout4, x4, y4, ci4, fs4, fc4;
    logic       s8 = 0, c8 = 0, sb8 = 0;
    logic [7:0] a8 = 0, b8 = 0, sum8;
    logic       busy8, done8, cout8, x8, y8, ci8, fs8, fc8;

    assign fs4 = x4 ^ y4 ^ ci4;
    assign fc4 = (x4 & y4) | (x4 & ci4) | (y4 & ci4);
    assign fs8 = x8 ^ y8 ^ ci8;
    assign fc8 = (x8 & y8) | (x8 & ci8) | (y8 & ci8);

    serial_add_ctrl #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4), .cin(c4),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sb4),
`endif
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
        .fa_x(x4), .fa_y(y4), .fa_cin(ci4), .fa_sum(fs4), .fa_carry(fc4)
    );

    serial_add_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .cin(c8),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sb8),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
        .fa_x(x8), .fa_y(y8), .fa_cin(ci8), .fa_sum(fs8), .fa_carry(fc8)
    );

    logic [4:0] last4 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: sub means a + ~b + 1 (cin ignored), else a + b + cin, all in 5 bits.
    function automatic logic [4:0] model4(input int a, input int b, input int ci, input int sb);
        if (sb != 0) return 5'((a & 15) + ((~b) & 15) + 1);
        return 5'((a & 15) + (b & 15) + (ci & 1));
    endfunction

    task automatic op4(input int a, input int b, input int ci, input int sb);
        logic [4:0] nw;
        logic [3:0] av, bv;
        av = 4'(a);
        bv = (sb != 0) ? ~4'(b) : 4'(b);
        a4 = 4'(a); b4 = 4'(b); c4 = ci[0]; sb4 = sb[0]; s4 = 1;
        tick();
        s4 = 0;
        a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
        for (int i = 0; i < 4; i++) begin
            chk("op4_busy", {62'd0, busy4, done4}, 64'b10);
            chk("op4_fa_x", x4, av[i]);
            chk("op4_fa_y", y4, bv[i]);
            chk("op4_hold", {cout4, sum4}, last4);
            tick();
        end
        nw = model4(a, b, ci, sb);
        chk("op4_done", {62'd0, busy4, done4}, 64'b01);
        chk("op4_result", {cout4, sum4}, nw);
        chk("op4_fa_idle", {x4, y4, ci4}, 0);
        last4 = nw;
        tick();
        chk("op4_done_low", done4, 0);
    endtask

    logic [3:0] ha[0:17], hb[0:17];
    logic       hc[0:17];
    int         lat;
    logic [8:0] exp8;

    initial begin
        #3;
        chk("rst_u4", {busy4, done4, sum4, cout4, x4, y4, ci4}, 0);
        chk("rst_u8", {busy8, done8, sum8, cout8, x8, y8, ci8}, 0);
        #9 rst_n = 1;
        tick();
        chk("idle_after_rst", {busy4, done4}, 0);

        op4(5, 3, 0, 0);
        op4(15, 15, 1, 0);
        op4(15, 1, 0, 0);
        op4(0, 0, 0, 0);

        // start held high with operands changing every cycle
        s4 = 1;
        for (int cyc = 0; cyc < 18; cyc++) begin
            ha[cyc] = 4'($urandom); hb[cyc] = 4'($urandom); hc[cyc] = 1'($urandom);
            a4 = ha[cyc]; b4 = hb[cyc]; c4 = hc[cyc];
            tick();
            chk("held_busy", busy4, (cyc % 6) < 4);
            chk("held_done", done4, (cyc % 6) == 4);
            if ((cyc % 6) == 4) begin
                last4 = model4(ha[cyc-4], hb[cyc-4], hc[cyc-4], 0);
                chk("held_result", {cout4, sum4}, last4);
            end
        end
        s4 = 0;
        tick();
        chk("held_idle", {busy4, done4}, 0);

        // asynchronous reset mid-RUN
        a4 = 4'd7; b4 = 4'd6; c4 = 1; s4 = 1;
        tick();
        s4 = 0;
        tick();
        tick();
        chk("mid_run_busy", busy4, 1);
        #2 rst_n = 0;
        #1;
        chk("async_rst", {busy4, done4, sum4, cout4, x4, y4, ci4}, 0);
        #3 rst_n = 1;
        last4 = 0;
        tick();
        op4(2, 2, 0, 0);

`ifdef SERIAL_ADD_SUB_EN
        op4(3, 5, 0, 1);
        op4(9, 4, 0, 1);
        op4(9, 4, 1, 0);
        op4(7, 7, 0, 1);
`endif

        for (int n = 0; n < 1000; n++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom); sb8 = 0;
            exp8 = 9'(a8) + 9'(b8) + 9'(c8);
            s8 = 1;
            tick();
            s8 = 0;
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            lat = 0;
            while (!done8 && lat < 20) begin
                tick();
                lat++;
            end
            chk("rnd_latency", lat, 8);
            chk("rnd_result", {cout8, sum8}, exp8);
            tick();
            chk("rnd_done_low", done8, 0);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
